arb_req_agent: RTL and testbench

//  Requester-side front end for one port of the fixed-priority 4-way arbiter.

---
 rtl/arb_req_agent.sv | 113 +++++++++++
 tb/tb_arb_req_agent.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_req_agent.sv
// arb_req_agent: queued-burst requester for one port of a fixed-priority arbiter.
// Optional starvation detector enabled by defining REQ_TIMEOUT_EN.
module arb_req_agent #(
    parameter int AW          = 16,
    parameter int LW          = 4,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [AW-1:0]            cmd_addr,
    input  logic [LW-1:0]            cmd_len,
    output logic                     req,
    input  logic                     gnt,
    output logic                     bus_valid,
    input  logic                     bus_ready,
    output logic [AW-1:0]            bus_addr,
    output logic                     bus_last,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     starve_err
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;
    state_t state, state_nxt;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [LW-1:0] mem_len  [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [AW-1:0] cur_addr;
    logic [LW-1:0] cur_len, beat;
    logic          push, pop, empty, accept, last_acc;

    assign empty     = fifo_cnt == '0;
    assign cmd_ready = fifo_cnt != (PW+1)'(DEPTH);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE || state == REL) && !empty;
    // the grant cycle in REQ already carries the first beat, hence REQ counts here
    assign req       = state == REQ || state == XFER;
    assign bus_valid = req && gnt;
    assign accept    = bus_valid && bus_ready;
    assign last_acc  = accept && beat == cur_len;
    assign bus_last  = bus_valid && beat == cur_len;
    assign bus_addr  = bus_valid ? cur_addr + AW'(beat) : '0;
    assign busy      = state != IDLE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = empty ? IDLE : REQ;
            REQ, XFER: state_nxt = last_acc ? REL : gnt ? XFER : state;
            REL:       state_nxt = empty ? IDLE : REQ;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            cur_addr <= '0;
            cur_len  <= '0;
            beat     <= '0;
        end else begin
            state    <= state_nxt;
            fifo_cnt <= fifo_cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                cur_addr <= mem_addr[rd_ptr];
                cur_len  <= mem_len[rd_ptr];
            end
            if (last_acc)
                beat <= '0;
            else if (accept)
                beat <= beat + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= cmd_addr;
            mem_len[wr_ptr]  <= cmd_len;
        end
    end

`ifdef REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
    logic          starving;

    assign starving = req && !gnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt       <= '0;
            starve_err <= 1'b0;
        end else begin
            tcnt <= !starving ? '0 : tcnt == TW'(TIMEOUT_CYC) ? tcnt : tcnt + 1'b1;
            if (starving && tcnt == TW'(TIMEOUT_CYC - 1))
                starve_err <= 1'b1;
        end
    end
`else
    assign starve_err = 1'b0;
`endif
endmodule

// File: tb/tb_arb_req_agent.sv
// tb_arb_req_agent: directed bench with a beat scoreboard and a registered-grant arbiter model.
module tb_arb_req_agent;
    localparam logic TO =
`ifdef REQ_TIMEOUT_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk = 0, rstn = 0, cmd_valid = 0, gnt = 0, bus_ready = 1, gnt_en = 1, req_q = 0;
    logic [15:0] cmd_addr = 0;
    logic [3:0]  cmd_len = 0;
    logic        cmd_ready, req, bus_valid, bus_last, busy, starve_err;
    logic [15:0] bus_addr;
    logic [2:0]  fifo_cnt;

    logic [31:0] sb [$];
    int passed = 0, total = 0, nbeat = 0, nreq = 0, nv = 0;
    logic prev_rel = 0, prev_req = 0;
    bit acc;

    arb_req_agent dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .req(req), .gnt(gnt),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_last(bus_last), .busy(busy), .fifo_cnt(fifo_cnt), .starve_err(starve_err)
    );

    always #5 clk = ~clk;

    // arbiter stand-in: grant is last cycle's request, gated by gnt_en
    always @(posedge clk) begin
        req_q = req;
        #1 gnt = req_q & gnt_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [15:0] a, input logic [3:0] l, output bit ok);
        cmd_valid = 1;
        cmd_addr  = a;
        cmd_len   = l;
        ok = cmd_ready;
        if (ok)
            for (int i = 0; i <= int'(l); i++)
                sb.push_back({15'd0, 1'(i == int'(l)), 16'(int'(a) + i)});
        cyc();
        cmd_valid = 0;
    endtask

    task automatic wait_req(input int lim);
        for (int i = 0; i < lim && !req; i++) cyc();
        chk("req_wait", 32'(req), 32'd1);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && (busy || fifo_cnt != 0); i++) cyc();
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    // sampled after the bench has set this cycle's inputs, so it sees what the next edge sees
    always @(negedge clk) begin
        #2;
        if (rstn) begin
            if (bus_valid && bus_ready) begin
                chk("beat", 32'({bus_last, bus_addr}), sb.size() != 0 ? sb.pop_front() : 32'hdeadbeef);
                nbeat++;
            end
            if (!bus_valid) chk("idle_bus", 32'({bus_last, bus_addr}), 32'd0);
            else            chk("valid_req", 32'(req), 32'd1);
            if (prev_rel)   chk("rel_gap", 32'(busy && !req), 32'd0);
            if (req && !prev_req) nreq++;
            prev_rel = busy && !req;
            prev_req = req;
        end else begin
            prev_rel = 0;
            prev_req = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal;
    end

    initial begin
        cyc(); cyc();
        chk("rst_req",    32'(req),        32'd0);
        chk("rst_valid",  32'(bus_valid),  32'd0);
        chk("rst_busy",   32'(busy),       32'd0);
        chk("rst_cnt",    32'(fifo_cnt),   32'd0);
        chk("rst_starve", 32'(starve_err), 32'd0);
        chk("rst_ready",  32'(cmd_ready),  32'd1);
        rstn = 1;
        cyc();

        // single 4-beat burst, 1-cycle req-to-beat latency, 1-cycle release
        nbeat = 0;
        push_cmd(16'h0100, 4'd3, acc);
        chk("t1_acc", 32'(acc), 32'd1);
        chk("t1_cnt", 32'(fifo_cnt), 32'd1);
        wait_req(10);
        chk("t1_lat0", 32'(bus_valid), 32'd0);
        cyc();
        chk("t1_first", 32'(bus_valid), 32'd1);
        chk("t1_addr0", 32'(bus_addr), 32'h0100);
        for (int i = 0; i < 20 && !(bus_last && bus_ready); i++) cyc();
        chk("t1_last", 32'(bus_addr), 32'h0103);
        cyc();
        chk("t1_rel_req",  32'(req),  32'd0);
        chk("t1_rel_busy", 32'(busy), 32'd1);
        cyc();
        chk("t1_idle",  32'(busy), 32'd0);
        chk("t1_beats", 32'(nbeat), 32'd4);
        chk("t1_sb",    32'(sb.size()), 32'd0);

        // fill the FIFO while the first command waits for a grant
        nreq = 0;
        gnt_en = 0;
        for (int k = 0; k < 5; k++) begin
            push_cmd(16'(16'h0300 + 16 * k), 4'(k % 3), acc);
            chk("t2_acc", 32'(acc), 32'd1);
        end
        chk("t2_full", 32'(cmd_ready), 32'd0);
        chk("t2_cnt",  32'(fifo_cnt), 32'd4);
        push_cmd(16'h0999, 4'd0, acc);
        chk("t2_refused", 32'(acc), 32'd0);
        chk("t2_cnt2",    32'(fifo_cnt), 32'd4);
        gnt_en = 1;
        wait_idle(200);
        chk("t2_reqs", 32'(nreq), 32'd5);
        chk("t2_sb",   32'(sb.size()), 32'd0);

        // preemption after beat 2 of an 8-beat burst
        nbeat = 0;
        push_cmd(16'h0200, 4'd7, acc);
        for (int i = 0; i < 20 && !(bus_valid && bus_ready && bus_addr == 16'h0202); i++) cyc();
        chk("t3_b2", 32'(bus_addr), 32'h0202);
        gnt_en = 0;
        repeat (3) begin
            cyc();
            chk("t3_hold_v",   32'(bus_valid), 32'd0);
            chk("t3_hold_req", 32'(req),       32'd1);
        end
        gnt_en = 1;
        cyc();
        chk("t3_resume_v", 32'(bus_valid), 32'd1);
        chk("t3_resume_a", 32'(bus_addr),  32'h0203);
        wait_idle(50);
        chk("t3_beats", 32'(nbeat), 32'd8);
        chk("t3_sb",    32'(sb.size()), 32'd0);

        // target stalls every other cycle: each beat takes two cycles
        nbeat = 0;
        nv = 0;
        push_cmd(16'h0400, 4'd3, acc);
        wait_req(10);
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (bus_valid) nv++;
            bus_ready = ~bus_ready;
        end
        bus_ready = 1;
        wait_idle(20);
        chk("t4_xfer_cycles", 32'(nv), 32'd8);
        chk("t4_beats", 32'(nbeat), 32'd4);
        chk("t4_sb",    32'(sb.size()), 32'd0);

        // address wrap, then reset in the middle of a burst
        nbeat = 0;
        push_cmd(16'hFFFE, 4'd3, acc);
        wait_idle(30);
        chk("t5_beats", 32'(nbeat), 32'd4);
        chk("t5_sb",    32'(sb.size()), 32'd0);
        push_cmd(16'hFFFE, 4'd3, acc);
        push_cmd(16'h0500, 4'd0, acc);
        for (int i = 0; i < 20 && !(bus_valid && bus_addr == 16'hFFFF); i++) cyc();
        chk("t5_b1",  32'(bus_addr), 32'hFFFF);
        chk("t5_pre_cnt", 32'(fifo_cnt), 32'd1);
        rstn = 0;
        #1;
        chk("t5_rst_req",   32'(req),       32'd0);
        chk("t5_rst_valid", 32'(bus_valid), 32'd0);
        chk("t5_rst_cnt",   32'(fifo_cnt),  32'd0);
        chk("t5_rst_busy",  32'(busy),      32'd0);
        sb.delete();
        cyc();
        rstn = 1;
        cyc(); cyc();
        chk("t5_post_req", 32'(req), 32'd0);

        // starvation: grant withheld for 64 cycles of requesting
        gnt_en = 0;
        push_cmd(16'h0600, 4'd0, acc);
        wait_req(10);
        repeat (63) cyc();
        chk("t6_pre", 32'(starve_err), 32'd0);
        cyc();
        chk("t6_set", 32'(starve_err), 32'(TO));
        gnt_en = 1;
        wait_idle(20);
        chk("t6_sticky", 32'(starve_err), 32'(TO));
        chk("t6_sb",     32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
